wb_stage: RTL and testbench

- Write-back stage of the 16-bit five-stage pipeline, directly downstream of the memory-access stage.
- Holds the MA/WB pipeline latch and selects load data or ALU result by opcode.
- Drives the register-file write port and the WB-to-EX forwarding bus.
- Keeps a retired-instruction counter.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/ma_wb_latch.sv | 33 +++
 rtl/wb_stage.sv | 95 +++++++++
 tb/tb_wb_stage.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline.
// Covers datapath widths, opcode constants and the write-back opcode decode.
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam int RA_W   = 3;
  localparam int INS_W  = 16;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_LOAD   = 4'h7;
  localparam opcode_t OP_STORE  = 4'h8;
  localparam opcode_t WB_OP_MAX = 4'h7;

  // Opcodes 0..7 produce a register result; store and everything above never write.
  function automatic logic is_wb_op(input opcode_t opcode);
    return (opcode <= WB_OP_MAX);
  endfunction

endpackage

// File: rtl/ma_wb_latch.sv
// Priority-encoded pipeline register with a valid bit.
// Priority order: rst > flush > stall > capture. Shared by every inter-stage latch.
module ma_wb_latch #(
  parameter int PAYLOAD_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 valid_in,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 valid_out,
  output logic [PAYLOAD_W-1:0] payload_out
);

  logic                 vld_p1;
  logic [PAYLOAD_W-1:0] payload_p1;

  // A flush clears the whole payload so a bubble never carries stale fields.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p1     <= 1'b0;
      payload_p1 <= '0;
    end else if (!stall) begin
      vld_p1     <= valid_in;
      payload_p1 <= payload_in;
    end
  end

  assign valid_out   = vld_p1;
  assign payload_out = payload_p1;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MA/WB latch, load/ALU result select, register-file write port,
// WB-to-EX forwarding bus and retired-instruction counter.
module wb_stage #(
  parameter int DATA_W       = pipe_pkg::DATA_W,
  parameter int RA_W         = pipe_pkg::RA_W,
  parameter int CNT_W        = 16,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_MA,
  input  logic              stall,
  input  logic              flush,
  input  logic [RA_W-1:0]   WBA_MA,
  input  logic [15:0]       INS_MA,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] ALU_result,
  output logic              RF_WE,
  output logic [RA_W-1:0]   RF_WA,
  output logic [DATA_W-1:0] RF_WD,
  output logic [15:0]       INS_WB,
  output logic              wb_valid,
  output logic              fwd_valid,
  output logic [RA_W-1:0]   fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_count
);

  import pipe_pkg::*;

  localparam int PAYLOAD_W = INS_W + RA_W + 2 * DATA_W;

  logic [PAYLOAD_W-1:0] payload_p0;
  logic [PAYLOAD_W-1:0] payload_p1;
  logic                 vld_p1;
  logic [INS_W-1:0]     ins_p1;
  logic [RA_W-1:0]      wba_p1;
  logic [DATA_W-1:0]    data_p1;
  logic [DATA_W-1:0]    alu_p1;
  opcode_t              opcode_p1;
  logic [DATA_W-1:0]    sel_p1;
  logic                 r0_block_p1;
  logic                 we_p1;
  logic                 capture_vld_p0;
  logic [CNT_W-1:0]     retire_q;

  assign payload_p0 = {INS_MA, WBA_MA, data, ALU_result};

  // ---- MA -> WB boundary ----
  ma_wb_latch #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_latch (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .stall       (stall),
    .valid_in    (valid_MA),
    .payload_in  (payload_p0),
    .valid_out   (vld_p1),
    .payload_out (payload_p1)
  );

  assign {ins_p1, wba_p1, data_p1, alu_p1} = payload_p1;

  assign opcode_p1   = opcode_t'(ins_p1[15:12]);
  assign sel_p1      = (opcode_p1 == OP_LOAD) ? data_p1 : alu_p1;
  assign r0_block_p1 = R0_HARDWIRED && (wba_p1 == '0);
  assign we_p1       = vld_p1 && is_wb_op(opcode_p1) && !r0_block_p1;

  // Address/data are squashed to zero whenever no write happens.
  assign RF_WE = we_p1;
  assign RF_WA = we_p1 ? wba_p1 : '0;
  assign RF_WD = we_p1 ? sel_p1 : '0;

  assign fwd_valid = RF_WE;
  assign fwd_addr  = RF_WA;
  assign fwd_data  = RF_WD;

  assign INS_WB   = ins_p1;
  assign wb_valid = vld_p1;

  // Counts on the capture edge itself, so stores/branches retire too; wraps silently.
  assign capture_vld_p0 = !flush && !stall && valid_MA;

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
    end else if (capture_vld_p0) begin
      retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage with hand-computed expectations.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, valid_MA, stall, flush;
  logic [2:0]  WBA_MA;
  logic [15:0] INS_MA, data, ALU_result;
  logic        RF_WE, wb_valid, fwd_valid;
  logic [2:0]  RF_WA, fwd_addr;
  logic [15:0] RF_WD, INS_WB, fwd_data, retire_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(
    .DATA_W(16), .RA_W(3), .CNT_W(16), .R0_HARDWIRED(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .valid_MA(valid_MA), .stall(stall), .flush(flush),
    .WBA_MA(WBA_MA), .INS_MA(INS_MA), .data(data), .ALU_result(ALU_result),
    .RF_WE(RF_WE), .RF_WA(RF_WA), .RF_WD(RF_WD), .INS_WB(INS_WB),
    .wb_valid(wb_valid), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .retire_count(retire_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Apply inputs, let one rising edge pass, then sample 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [2:0] wba,
                       input logic [15:0] d, input logic [15:0] alu);
    valid_MA = v; INS_MA = ins; WBA_MA = wba; data = d; ALU_result = alu;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic [15:0] cnt);
    chk({tag, ".we"},   RF_WE, we);
    chk({tag, ".wa"},   RF_WA, wa);
    chk({tag, ".wd"},   RF_WD, wd);
    chk({tag, ".fv"},   fwd_valid, we);
    chk({tag, ".fa"},   fwd_addr, wa);
    chk({tag, ".fd"},   fwd_data, wd);
    chk({tag, ".cnt"},  retire_count, cnt);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_rf(tag, 1'b0, 3'd0, 16'h0000, 16'h0000);
    chk({tag, ".ins"}, INS_WB, 16'h0000);
    chk({tag, ".vld"}, wb_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b1;
    drive(1'b1, 16'h1A45, 3'd3, 16'h1111, 16'h2222);
    step();
    chk_all_zero("reset");

    rst = 1'b0; flush = 1'b0;
    drive(1'b1, 16'h1A45, 3'd3, 16'h1111, 16'h00FF);
    step();
    chk_rf("alu", 1'b1, 3'd3, 16'h00FF, 16'd1);
    chk("alu.ins", INS_WB, 16'h1A45);
    chk("alu.vld", wb_valid, 1'b1);

    drive(1'b1, 16'h7123, 3'd5, 16'hBEEF, 16'h0040);
    step();
    chk_rf("load", 1'b1, 3'd5, 16'hBEEF, 16'd2);

    drive(1'b1, 16'h8456, 3'd4, 16'h3333, 16'h4444);
    step();
    chk_rf("store", 1'b0, 3'd0, 16'h0000, 16'd3);
    chk("store.vld", wb_valid, 1'b1);

    drive(1'b1, 16'h2001, 3'd0, 16'h6666, 16'h5555);
    step();
    chk_rf("r0", 1'b0, 3'd0, 16'h0000, 16'd4);

    drive(1'b1, 16'hC00F, 3'd1, 16'h7777, 16'h8888);
    step();
    chk_rf("branch", 1'b0, 3'd0, 16'h0000, 16'd5);

    drive(1'b1, 16'h6ABC, 3'd7, 16'h9999, 16'h0AAA);
    step();
    chk_rf("op6", 1'b1, 3'd7, 16'h0AAA, 16'd6);

    drive(1'b0, 16'h1DEF, 3'd2, 16'hAAAA, 16'hBBBB);
    step();
    chk_rf("bubble", 1'b0, 3'd0, 16'h0000, 16'd6);
    chk("bubble.vld", wb_valid, 1'b0);
    chk("bubble.ins", INS_WB, 16'h1DEF);

    drive(1'b1, 16'h1000, 3'd2, 16'hDDDD, 16'h1234);
    step();
    chk_rf("stall0", 1'b1, 3'd2, 16'h1234, 16'd7);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h7FFF - 16'(i), 3'd6, 16'hE000 + 16'(i), 16'hF000 + 16'(i));
      step();
      chk_rf($sformatf("stall%0d", i + 1), 1'b1, 3'd2, 16'h1234, 16'd7);
    end

    stall = 1'b0;
    drive(1'b1, 16'h7000, 3'd1, 16'hCAFE, 16'h0001);
    step();
    chk_rf("ld2", 1'b1, 3'd1, 16'hCAFE, 16'd8);
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 16'h1111, 3'd4, 16'h0002, 16'h0003);
    step();
    chk_rf("flush", 1'b0, 3'd0, 16'h0000, 16'd8);
    chk("flush.vld", wb_valid, 1'b0);
    chk("flush.ins", INS_WB, 16'h0000);

    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 16'h8000, 3'd1, 16'h0000, 16'h0000);
    repeat (65535 - 8) @(posedge clk);
    #1;
    chk("wrap.max", retire_count, 16'hFFFF);
    step();
    chk("wrap.zero", retire_count, 16'h0000);

    drive(1'b1, 16'h1000, 3'd3, 16'h0000, 16'h7777);
    step();
    chk_rf("pre_rst", 1'b1, 3'd3, 16'h7777, 16'd1);
    rst = 1'b1; stall = 1'b1;
    drive(1'b1, 16'h3000, 3'd5, 16'h1212, 16'h3434);
    step();
    chk_all_zero("mid_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
